alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/alu_arbiter_rr_arb2.sv | 17 +
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode constants and FSM state encoding.
package alu_arbiter_pkg;

  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_SUB = 6'h02;
  localparam logic [5:0] OP_MUL = 6'h03;
  localparam logic [5:0] OP_SHR = 6'h04;
  localparam logic [5:0] OP_SHL = 6'h05;
  localparam logic [5:0] OP_AND = 6'h06;
  localparam logic [5:0] OP_OR  = 6'h07;
  localparam logic [5:0] OP_NOR = 6'h08;
  localparam logic [5:0] OP_SLT = 6'h09;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-port round-robin picker: a lone requester wins, a tie goes to
// the port that was not granted last.
module rr_arb2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = (req_i == 2'b11) ? ~last_i : req_i[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: latches the granted
// operands onto the ALU, waits the settle time, then captures and returns the result.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int OPRN_WIDTH  = 6,
  parameter int EXEC_CYCLES = 1,
  parameter int MUL_CYCLES  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            REQ,
  input  logic [DATA_WIDTH-1:0] OP1_0,
  input  logic [DATA_WIDTH-1:0] OP2_0,
  input  logic [OPRN_WIDTH-1:0] OPRN_0,
  input  logic [DATA_WIDTH-1:0] OP1_1,
  input  logic [DATA_WIDTH-1:0] OP2_1,
  input  logic [OPRN_WIDTH-1:0] OPRN_1,
  output logic [1:0]            DONE,
  output logic [DATA_WIDTH-1:0] RES,
  output logic                  ZERO_OUT,
  output logic                  ERR,
  output logic                  BUSY,
  output logic [DATA_WIDTH-1:0] ALU_OP1,
  output logic [DATA_WIDTH-1:0] ALU_OP2,
  output logic [OPRN_WIDTH-1:0] ALU_OPRN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZERO
);

  localparam int MAX_CYC = (MUL_CYCLES > EXEC_CYCLES) ? MUL_CYCLES : EXEC_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  last_q;
  logic                  grant_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, res_q;
  logic [OPRN_WIDTH-1:0] oprn_q;
  logic                  zero_q, err_q;
  logic [1:0]            done_q;

  logic                  arb_grant, arb_valid;
  logic [DATA_WIDTH-1:0] sel_op1, sel_op2;
  logic [OPRN_WIDTH-1:0] sel_oprn;
  logic [CNT_W-1:0]      load_cnt;
  logic                  oprn_illegal;

  rr_arb2 u_rr_arb2 (
    .req_i   (REQ),
    .last_i  (last_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  always_comb begin
    sel_op1      = arb_grant ? OP1_1  : OP1_0;
    sel_op2      = arb_grant ? OP2_1  : OP2_0;
    sel_oprn     = arb_grant ? OPRN_1 : OPRN_0;
    // counter is loaded with settle-1 so the capture lands on its zero cycle
    load_cnt     = (sel_oprn == OPRN_WIDTH'(OP_MUL)) ? CNT_W'(MUL_CYCLES - 1)
                                                     : CNT_W'(EXEC_CYCLES - 1);
    oprn_illegal = (oprn_q == '0) || (oprn_q > OPRN_WIDTH'(OP_SLT));
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      oprn_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_grant;
            last_q  <= arb_grant;
            op1_q   <= sel_op1;
            op2_q   <= sel_op2;
            oprn_q  <= sel_oprn;
            cnt_q   <= load_cnt;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            res_q           <= ALU_OUT;
            zero_q          <= ALU_ZERO;
            err_q           <= oprn_illegal;
            done_q[grant_q] <= 1'b1;
            state_q         <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DONE     = done_q;
  assign RES      = res_q;
  assign ZERO_OUT = zero_q;
  assign ERR      = err_q;
  assign BUSY     = (state_q != S_IDLE);
  assign ALU_OP1  = op1_q;
  assign ALU_OP2  = op2_q;
  assign ALU_OPRN = oprn_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU plus a transaction-level
// model of grant order, latency and returned result.
module tb_alu_arbiter;

  localparam int MUL_N  = 4;
  localparam int EXEC_N = 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  REQ;
  logic [31:0] OP1_0, OP2_0, OP1_1, OP2_1;
  logic [5:0]  OPRN_0, OPRN_1;
  logic [1:0]  DONE;
  logic [31:0] RES;
  logic        ZERO_OUT, ERR, BUSY;
  logic [31:0] ALU_OP1, ALU_OP2, ALU_OUT;
  logic [5:0]  ALU_OPRN;
  logic        ALU_ZERO;

  int n_chk  = 0;
  int n_fail = 0;
  int last_m;

  always #5 CLK = ~CLK;

  alu_arbiter #(
    .DATA_WIDTH  (32),
    .OPRN_WIDTH  (6),
    .EXEC_CYCLES (EXEC_N),
    .MUL_CYCLES  (MUL_N)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .OP1_0    (OP1_0),
    .OP2_0    (OP2_0),
    .OPRN_0   (OPRN_0),
    .OP1_1    (OP1_1),
    .OP2_1    (OP2_1),
    .OPRN_1   (OPRN_1),
    .DONE     (DONE),
    .RES      (RES),
    .ZERO_OUT (ZERO_OUT),
    .ERR      (ERR),
    .BUSY     (BUSY),
    .ALU_OP1  (ALU_OP1),
    .ALU_OP2  (ALU_OP2),
    .ALU_OPRN (ALU_OPRN),
    .ALU_OUT  (ALU_OUT),
    .ALU_ZERO (ALU_ZERO)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] op);
    case (op)
      6'h01:   return a + b;
      6'h02:   return a - b;
      6'h03:   return a * b;
      6'h04:   return a >> b;
      6'h05:   return a << b;
      6'h06:   return a & b;
      6'h07:   return a | b;
      6'h08:   return ~(a | b);
      6'h09:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic int settle(input logic [5:0] op);
    return (op == 6'h03) ? MUL_N : EXEC_N;
  endfunction

  function automatic logic illegal(input logic [5:0] op);
    return (op == 6'h00) || (op > 6'h09);
  endfunction

  always_comb ALU_OUT = alu_ref(ALU_OP1, ALU_OP2, ALU_OPRN);
  assign ALU_ZERO = (ALU_OUT == 32'd0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_done"}, DONE, 2'b00);
    check({tag, "_res"}, RES, 32'd0);
    check({tag, "_zero"}, ZERO_OUT, 1'b0);
    check({tag, "_err"}, ERR, 1'b0);
    check({tag, "_busy"}, BUSY, 1'b0);
    check({tag, "_aop1"}, ALU_OP1, 32'd0);
    check({tag, "_aop2"}, ALU_OP2, 32'd0);
    check({tag, "_aoprn"}, ALU_OPRN, 6'd0);
  endtask

  task automatic drive_port(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] op);
    if (p == 0) begin
      OP1_0 = a; OP2_0 = b; OPRN_0 = op;
    end else begin
      OP1_1 = a; OP2_1 = b; OPRN_1 = op;
    end
  endtask

  // Waits (bounded) for DONE starting at a negedge; exp_lat counts negedges until DONE.
  task automatic expect_done(input string tag, input int p, input int exp_lat,
                             input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                             input logic [31:0] exp_res);
    int k;
    int n;
    logic [1:0] onehot;
    n = settle(op);
    onehot = (p == 0) ? 2'b01 : 2'b10;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
      if (k == exp_lat - n || k == exp_lat - 1) begin
        check({tag, "_aoprn"}, ALU_OPRN, op);
        check({tag, "_aop1"}, ALU_OP1, a);
        check({tag, "_aop2"}, ALU_OP2, b);
        check({tag, "_busy_exec"}, BUSY, 1'b1);
      end
    end while (DONE == 2'b00 && k < 20);
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_done"}, DONE, onehot);
    check({tag, "_res"}, RES, exp_res);
    check({tag, "_zero"}, ZERO_OUT, exp_res == 32'd0);
    check({tag, "_err"}, ERR, illegal(op));
    check({tag, "_busy_resp"}, BUSY, 1'b1);
  endtask

  task automatic run_single(input string tag, input int p, input logic [31:0] a,
                            input logic [31:0] b, input logic [5:0] op,
                            input logic [31:0] exp_res);
    drive_port(p, a, b, op);
    REQ = (p == 0) ? 2'b01 : 2'b10;
    expect_done(tag, p, settle(op) + 1, a, b, op, exp_res);
    last_m = p;
    REQ = 2'b00;
    @(negedge CLK);
    check({tag, "_done_clear"}, DONE, 2'b00);
    check({tag, "_res_hold"}, RES, exp_res);
    check({tag, "_err_hold"}, ERR, illegal(op));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [5:0]  po [2];
    int w;
    int lat;

    RST = 1'b0;
    REQ = 2'b00;
    drive_port(0, 32'd0, 32'd0, 6'd0);
    drive_port(1, 32'd0, 32'd0, 6'd0);
    repeat (2) @(negedge CLK);
    check_reset("por");
    RST = 1'b1;
    last_m = 1;

    // Directed cases
    run_single("add", 0, 32'd5, 32'd3, 6'h01, 32'd8);
    run_single("sub", 1, 32'd7, 32'd7, 6'h02, 32'd0);
    run_single("mul", 0, 32'h0001_0000, 32'd3, 6'h03, 32'h0003_0000);
    run_single("illegal", 0, 32'h1234, 32'h00FF, 6'h0A,
               32'h1234 ^ 32'h00FF ^ 32'h5A5A_5A5A);
    run_single("after_illegal", 0, 32'd10, 32'd4, 6'h01, 32'd14);
    run_single("zero_op", 1, 32'd1, 32'd2, 6'h00, 32'd1 ^ 32'd2 ^ 32'h5A5A_5A5A);

    // Random single-port operations
    for (int i = 0; i < 20; i++) begin
      int p;
      logic [31:0] a, b;
      logic [5:0] op;
      p  = int'($urandom_range(0, 1));
      a  = $urandom;
      b  = (i % 3 == 0) ? a : $urandom_range(0, 40);
      op = 6'($urandom_range(0, 15));
      run_single("rnd_single", p, a, b, op, alu_ref(a, b, op));
    end

    // Both ports requesting continuously: strict alternation, N+2 apart
    for (int p = 0; p < 2; p++) begin
      pa[p] = $urandom;
      pb[p] = $urandom_range(0, 33);
      po[p] = 6'($urandom_range(1, 9));
      drive_port(p, pa[p], pb[p], po[p]);
    end
    REQ = 2'b11;
    w   = 1 - last_m;
    lat = settle(po[w]) + 1;
    for (int i = 0; i < 16; i++) begin
      expect_done("tie", w, lat, pa[w], pb[w], po[w], alu_ref(pa[w], pb[w], po[w]));
      last_m = w;
      pa[w] = $urandom;
      pb[w] = $urandom_range(0, 33);
      po[w] = 6'($urandom_range(0, 12));
      drive_port(w, pa[w], pb[w], po[w]);
      w   = 1 - w;
      lat = settle(po[w]) + 2;
    end
    REQ = 2'b00;
    @(negedge CLK);

    // Reset in the middle of a multiply; pending tie then goes to port 0
    drive_port(0, 32'h0001_0000, 32'd3, 6'h03);
    drive_port(1, 32'd9, 32'd9, 6'h03);
    REQ = 2'b11;
    repeat (2) @(negedge CLK);
    check("mid_busy", BUSY, 1'b1);
    RST = 1'b0;
    @(negedge CLK);
    check_reset("midrst");
    repeat (2) begin
      @(negedge CLK);
      check("midrst_no_done", DONE, 2'b00);
    end
    RST = 1'b1;
    last_m = 1;
    expect_done("post_rst_p0", 0, MUL_N + 1, 32'h0001_0000, 32'd3, 6'h03, 32'h0003_0000);
    expect_done("post_rst_p1", 1, MUL_N + 2, 32'd9, 32'd9, 6'h03, 32'd81);
    REQ = 2'b00;
    @(negedge CLK);
    check("final_done_clear", DONE, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
